// File: rtl/load_store_unit.sv
// Memory-access stage: takes the execute-stage effective address, store data
// and funct3, issues a single access on a req/gnt/rvalid data bus, builds
// byte strobes with lane-replicated store data, extracts and extends load data,
// stalls the pipeline until completion and reports misaligned accesses,
// illegal funct3 encodings and bus timeouts.
module load_store_unit #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        lsu_err,
    output logic [1:0]  err_code,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_MISALGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

    // Last counter value a phase may reach before it is declared timed out.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       funct3_r;
    logic             is_store_r;
    logic [1:0]       off_r;

    logic             legal_s;
    logic             misaligned_s;

    // funct3 encodings accepted for loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW).
    function automatic logic funct3_legal(input logic st, input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = ~st;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Halfwords need an even address, words need a 4-byte aligned address.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        case (f3[1:0])
            2'b01:   bad = off[0];
            2'b10:   bad = (off != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Byte strobes for a store of the given width at the given byte offset.
    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] s;
        case (f3)
            3'b000:  s = 4'b0001 << off;
            3'b001:  s = off[1] ? 4'b1100 : 4'b0011;
            3'b010:  s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    // Store data replicated into every lane so the strobes alone pick the bytes.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        case (f3)
            3'b000:  r = {4{d[7:0]}};
            3'b001:  r = {2{d[15:0]}};
            3'b010:  r = d;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Pick the addressed byte/halfword out of the read word and extend it.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'b00:   b = rd[7:0];
            2'b01:   b = rd[15:8];
            2'b10:   b = rd[23:16];
            2'b11:   b = rd[31:24];
            default: b = 8'd0;
        endcase
        h = off[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = rd;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Classify the incoming request before it is accepted.
    always_comb begin
        legal_s      = funct3_legal(is_store, funct3);
        misaligned_s = is_misaligned(funct3, addr[1:0]);
    end

    // Hold the pipeline while a request is being accepted or is in flight.
    always_comb begin
        if (state_r == IDLE) begin
            stall = start;
        end else if ((state_r == REQ) || (state_r == WAIT_R)) begin
            stall = 1'b1;
        end else begin
            stall = 1'b0;
        end
    end

    // Access sequencer with registered bus and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            funct3_r   <= 3'b000;
            is_store_r <= 1'b0;
            off_r      <= 2'b00;
            done       <= 1'b0;
            lsu_err    <= 1'b0;
            err_code   <= ERR_NONE;
            load_data  <= 32'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wstrb  <= 4'b0000;
            mem_wdata  <= 32'd0;
        end else begin
            // Completion and error flags are single-cycle pulses by default.
            done     <= 1'b0;
            lsu_err  <= 1'b0;
            err_code <= ERR_NONE;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        funct3_r   <= funct3;
                        is_store_r <= is_store;
                        off_r      <= addr[1:0];
                        cnt_r      <= '0;
                        if (!legal_s) begin
                            state_r  <= DONE;
                            done     <= 1'b1;
                            lsu_err  <= 1'b1;
                            err_code <= ERR_ILLEGAL;
                        end else if (misaligned_s) begin
                            state_r  <= DONE;
                            done     <= 1'b1;
                            lsu_err  <= 1'b1;
                            err_code <= ERR_MISALGN;
                        end else begin
                            state_r   <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_wstrb <= is_store ? store_strb(funct3, addr[1:0]) : 4'b0000;
                            mem_wdata <= is_store ? store_data(funct3, wdata) : 32'd0;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    // A grant in the expiry cycle still wins over the timeout.
                    if (mem_gnt) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= 4'b0000;
                        if (is_store_r) begin
                            state_r <= DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r <= WAIT_R;
                            cnt_r   <= '0;
                        end
                    end else if (cnt_r == CNT_LAST) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= 4'b0000;
                        state_r   <= DONE;
                        done      <= 1'b1;
                        lsu_err   <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                        load_data <= 32'd0;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                WAIT_R: begin
                    // Read data arriving in the expiry cycle still wins over the timeout.
                    if (mem_rvalid) begin
                        load_data <= load_extract(funct3_r, off_r, mem_rdata);
                        state_r   <= DONE;
                        done      <= 1'b1;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r   <= DONE;
                        done      <= 1'b1;
                        lsu_err   <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                        load_data <= 32'd0;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                DONE: begin
                    // A start seen here is not accepted; execute re-presents it in IDLE.
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases followed by random
// operations, with a bus responder and an arithmetic reference model.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic        lsu_err;
    logic [1:0]  err_code;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int          total  = 0;
    int          passed = 0;
    logic [31:0] exp_ld = 32'd0;

    load_store_unit #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
        .addr(addr), .wdata(wdata), .stall(stall), .done(done), .load_data(load_data),
        .lsu_err(lsu_err), .err_code(err_code), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    // One operation: model computes expectations, responder drives gnt/rvalid
    // after gd / rdl idle cycles of the respective phase.
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rdv,
                          input int gd, input int rdl);
        int              size, off, exp_cyc, nreq, nwait, cyc, rq, wt;
        logic            legal, misal, to, granted, saw_req, got_done;
        logic [1:0]      exp_err;
        logic [3:0]      exp_strb;
        logic [31:0]     exp_wd;
        longint unsigned mask, v;

        legal = st ? (f3 <= 3'd2) : ((f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5));
        size  = 1 << f3[1:0];
        off   = int'(a[1:0]);
        misal = (off % size) != 0;
        to    = (gd > TO - 1) || (!st && rdl > TO - 1);
        if (!legal) begin
            exp_err = 2'd3; exp_cyc = 1;
        end else if (misal) begin
            exp_err = 2'd1; exp_cyc = 1;
        end else begin
            exp_err = to ? 2'd2 : 2'd0;
            nreq    = (gd > TO - 1) ? TO : gd + 1;
            nwait   = (st || gd > TO - 1) ? 0 : ((rdl > TO - 1) ? TO : rdl + 1);
            exp_cyc = nreq + nwait + 1;
        end
        exp_strb = 4'(((1 << size) - 1) << off);
        exp_wd   = (size == 1) ? wd[7:0] * 32'h0101_0101 :
                   (size == 2) ? wd[15:0] * 32'h0001_0001 : wd;
        mask = (64'd1 << (8 * size)) - 64'd1;
        v    = (64'(rdv) >> (8 * off)) & mask;
        if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
        if (legal && !misal) begin
            if (to) exp_ld = 32'd0;
            else if (!st) exp_ld = v[31:0];
        end

        @(negedge clk);
        start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        #1;
        chk("stall_on_start", {31'd0, stall}, 32'd1);
        cyc = 0; rq = 0; wt = 0; granted = 1'b0; saw_req = 1'b0; got_done = 1'b0;
        while (cyc < 30 && !got_done) begin
            @(negedge clk);
            cyc++;
            start = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (done) begin
                got_done = 1'b1;
            end else begin
                chk("stall_busy", {31'd0, stall}, 32'd1);
                if (mem_req) begin
                    saw_req = 1'b1;
                    chk("mem_addr", mem_addr, a & ~32'd3);
                    chk("mem_we", {31'd0, mem_we}, {31'd0, st});
                    chk("mem_wstrb", {28'd0, mem_wstrb}, st ? {28'd0, exp_strb} : 32'd0);
                    if (st) chk("mem_wdata", mem_wdata, exp_wd);
                    mem_gnt = (rq == gd);
                    if (mem_gnt) granted = 1'b1;
                    rq++;
                end else if (granted) begin
                    mem_rvalid = (wt == rdl);
                    if (mem_rvalid) mem_rdata = rdv;
                    wt++;
                end
            end
        end
        chk("done_seen", {31'd0, got_done}, 32'd1);
        chk("latency", cyc, exp_cyc);
        chk("lsu_err", {31'd0, lsu_err}, {31'd0, (exp_err != 2'd0)});
        chk("err_code", {30'd0, err_code}, {30'd0, exp_err});
        chk("load_data", load_data, exp_ld);
        chk("stall_done", {31'd0, stall}, 32'd0);
        chk("req_in_done", {31'd0, mem_req}, 32'd0);
        chk("req_issued", {31'd0, saw_req}, {31'd0, (legal && !misal)});
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("err_pulse", {31'd0, lsu_err}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {30'd0, lsu_err, err_code[0]}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_ld", load_data, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wstrb", {27'd0, mem_we, mem_wstrb}, 32'd0);
        rst = 1'b0;

        // Directed cases from the plan, plus expiry-cycle priority.
        run_op(1'b0, 3'b010, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 0, 0);
        run_op(1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h8012_3456, 0, 0);
        run_op(1'b0, 3'b100, 32'h0000_0103, 32'd0, 32'h8012_3456, 0, 0);
        run_op(1'b0, 3'b101, 32'h0000_0102, 32'd0, 32'h8012_3456, 0, 0);
        run_op(1'b0, 3'b001, 32'h0000_0102, 32'd0, 32'h8012_3456, 1, 2);
        run_op(1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 32'd0, 3, 0);
        run_op(1'b1, 3'b000, 32'h0000_0041, 32'h0000_00A5, 32'd0, 0, 0);
        run_op(1'b1, 3'b010, 32'h0000_0040, 32'hCAFE_F00D, 32'd0, 2, 0);
        run_op(1'b0, 3'b010, 32'h0000_0101, 32'd0, 32'd0, 0, 0);
        run_op(1'b0, 3'b011, 32'h0000_0100, 32'd0, 32'd0, 0, 0);
        run_op(1'b1, 3'b100, 32'h0000_0100, 32'd0, 32'd0, 0, 0);
        run_op(1'b0, 3'b010, 32'h0000_0200, 32'd0, 32'h1111_2222, 99, 0);
        run_op(1'b0, 3'b010, 32'h0000_0204, 32'd0, 32'h3333_4444, 3, 3);
        run_op(1'b0, 3'b100, 32'h0000_0205, 32'd0, 32'h0000_7700, 0, 99);
        run_op(1'b1, 3'b010, 32'h0000_0208, 32'h5555_6666, 32'd0, 99, 0);

        // Randomized operations.
        for (int i = 0; i < 60; i++) begin
            run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                   $urandom, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
        end

        // Reset while waiting for read data abandons the load.
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0300;
        @(negedge clk);
        start = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("wait_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_ld = 32'd0;
        chk("rstw_req", {31'd0, mem_req}, 32'd0);
        chk("rstw_stall", {31'd0, stall}, 32'd0);
        chk("rstw_done", {31'd0, done}, 32'd0);
        chk("rstw_ld", load_data, exp_ld);
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("late_rvalid_done", {31'd0, done}, 32'd0);
            chk("late_rvalid_ld", load_data, exp_ld);
        end
        mem_rvalid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage that consumes the execute stage's outputs: ALUResult as the effective address, rdata2 as store data, and funct3 as the access width and sign.
It issues one access at a time on a simple req/gnt/rvalid data-memory bus.
It produces write strobes with lane-replicated store data, and extracts and extends load data.
It stalls the pipeline until the access completes, and reports misalignment, illegal funct3 and bus timeout.

Parameters:
TIMEOUT, 255, max cycles allowed in REQ, and separately in WAIT_R, before a bus-timeout error; must be >= 2.
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  memory op present from execute; sampled only in IDLE
is_store  input  1  1: store, 0: load
funct3  input  3  RV32I load/store funct3
addr  input  32  effective address (ALUResult)
wdata  input  32  store data (rdata2)
stall  output  1  hold pipeline upstream
done  output  1  one-cycle completion pulse
load_data  output  32  extended load result; valid with done, held until next done
lsu_err  output  1  error flag; pulses with done only
err_code  output  2  00 none, 01 misaligned, 10 bus timeout, 11 illegal funct3; valid with lsu_err
mem_req  output  1  bus request
mem_we  output  1  bus write enable
mem_addr  output  32  word address {addr[31:2],2'b00}
mem_wstrb  output  4  byte strobes (stores only, 0 for loads)
mem_wdata  output  32  lane-replicated store data
mem_gnt  input  1  request accepted this cycle
mem_rvalid  input  1  read data valid
mem_rdata  input  32  read data

Behaviour:
- States: IDLE, REQ, WAIT_R, DONE.
- Reset (synchronous): state IDLE, counter 0, all outputs 0 including load_data. Any transaction in flight is abandoned, and mem_req is 0 from the first cycle after the reset edge.
- stall = (IDLE & start) | REQ | WAIT_R. stall is 0 in DONE, so the pipeline advances on the done cycle.
- In IDLE with start=1: latch addr, wdata, funct3 and is_store. Then:
  - Illegal funct3 goes to DONE with err 11. Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW.
  - Misaligned goes to DONE with err 01: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Otherwise go to REQ with counter cleared.
  - Illegal and misaligned ops never assert mem_req.
- REQ:
  - mem_req=1; all mem_* outputs are driven from latched values and stay stable until gnt.
  - On mem_gnt: a store goes to DONE; a load goes to WAIT_R with counter cleared.
- WAIT_R:
  - mem_rvalid is honoured only in this state, so it arrives at earliest the cycle after gnt.
  - On rvalid: capture the extracted data and go to DONE.
- Timeout:
  - The counter increments each cycle in REQ and in WAIT_R.
  - If it reaches TIMEOUT-1 with no gnt (REQ) or no rvalid (WAIT_R) that cycle, go to DONE with err 10 and load_data=0.
  - A progress event in the expiry cycle takes priority over the timeout.
- DONE: done=1 for one cycle; lsu_err=1 if an error is pending; then go to IDLE. start in DONE is ignored.
- Store lanes:
  - SB: wstrb = 0001 << addr[1:0], wdata = {4{wdata[7:0]}}.
  - SH: wstrb = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111, wdata unchanged.
- Load extraction:
  - Byte = rdata[8*addr[1:0] +: 8]; halfword = rdata[16*addr[1] +: 16].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes rdata through.
- load_data is updated only on a successful load or a timeout (written to 0). It is held through stores and other errors.
- Minimum latency, start to done: store 2 cycles (gnt in first REQ cycle), load 3 cycles, error 1 cycle.

Test Plan:
- LW at addr 0x100, gnt in 1st REQ cycle, rvalid next cycle with rdata 0xDEADBEEF -> load_data=0xDEADBEEF; done 3 cycles after start; mem_addr=0x100, mem_we=0.
- LB at 0x103 with rdata 0x80123456 -> load_data=0xFFFFFF80. LBU with the same stimulus -> 0x00000080. LHU at 0x102 -> 0x00008012.
- SH at 0x102 with wdata 0x1234ABCD, gnt delayed 3 cycles -> mem_wstrb=1100 and mem_wdata=0xABCDABCD held stable 4 cycles; stall high until done; mem_we=1.
- LW at 0x101 -> no mem_req, done+lsu_err next cycle with err_code=01. funct3=011 load -> err_code=11.
- Load with gnt never asserted, TIMEOUT=4 -> done, lsu_err, err_code=10, load_data=0 after 4 REQ cycles; mem_req drops in the DONE cycle.
- rst asserted in WAIT_R -> next cycle state IDLE, mem_req/stall/done=0, load_data=0; a later rvalid is ignored.
